mips_cpu_mem_unit: RTL and testbench

// - Load/store unit between the multicycle core FSM (FETCH/MEMORY states) and the Avalon-MM master bus.
// - Accepts one byte/half/word request at a time and drives address/read/write/byteenable/writedata.
// - Honours waitrequest and returns the lane-extracted, sign- or zero-extended read data to the core.
// - Core sees a simple valid/ready request and a one-cycle response pulse.

---
 rtl/mips_cpu_mem_unit_if.sv | 12 +
 rtl/mips_cpu_mem_unit.sv | 105 ++++++++++
 tb/tb_mips_cpu_mem_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_mem_unit_if.sv
// mips_cpu_mem_unit_if: Avalon-MM master bus between the load/store unit and memory
interface mips_cpu_mem_unit_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  modport master (output address, read, write, writedata, byteenable, input waitrequest, readdata);
  modport slave  (input address, read, write, writedata, byteenable, output waitrequest, readdata);
endinterface

// File: rtl/mips_cpu_mem_unit.sv
// mips_cpu_mem_unit: load/store unit bridging core requests to Avalon-MM; MEM_MISALIGN_TRAP_EN traps misaligned half/word
module mips_cpu_mem_unit #(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  mips_cpu_mem_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} stateType;
  stateType    state;
  logic [1:0]  sizeReg;
  logic        signedReg;
  logic [1:0]  offReg;
  logic [31:0] waitCnt;
  logic [1:0]  laneOff;
  logic [3:0]  laneMask;
  logic [31:0] laneBits;
  logic [31:0] shifted;
  logic [31:0] loadData;
  logic        trap;
  assign req_ready = state == IDLE;
  assign laneOff  = req_size == 2'b00 ? req_addr[1:0] : req_size == 2'b01 ? {req_addr[1], 1'b0} : 2'b00;
  assign laneMask = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] : req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign laneBits = {{8{laneMask[3]}}, {8{laneMask[2]}}, {8{laneMask[1]}}, {8{laneMask[0]}}};
  assign shifted  = bus.readdata >> {offReg, 3'b000};
  assign loadData = sizeReg == 2'b00 ? {{24{signedReg & shifted[7]}}, shifted[7:0]} :
                    sizeReg == 2'b01 ? {{16{signedReg & shifted[15]}}, shifted[15:0]} : bus.readdata;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif
  // request FSM with registered bus strobes and response; a trapped request sits in BUS with no strobe for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      sizeReg        <= '0;
      signedReg      <= 1'b0;
      offReg         <= '0;
      waitCnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state          <= BUS;
          bus.address    <= {req_addr[31:2], 2'b00};
          bus.byteenable <= laneMask;
          bus.writedata  <= req_write ? (req_wdata << {laneOff, 3'b000}) & laneBits : '0;
          bus.read       <= !req_write && !trap;
          bus.write      <= req_write && !trap;
          sizeReg        <= req_size;
          signedReg      <= req_signed;
          offReg         <= laneOff;
          waitCnt        <= '0;
        end
        BUS: if (!(bus.read || bus.write)) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
        end else if (!bus.waitrequest) begin
          state      <= bus.write ? RESP : RDATA;
          resp_valid <= bus.write;
          bus.read   <= 1'b0;
          bus.write  <= 1'b0;
        end else if (WAIT_LIMIT != 0 && waitCnt == WAIT_LIMIT - 1) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          bus.read   <= 1'b0;
          bus.write  <= 1'b0;
        end else begin
          waitCnt <= waitCnt + 1;
        end
        RDATA: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= loadData;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_mem_unit.sv
// tb_mips_cpu_mem_unit: directed self-checking bench for the load/store unit
module tb_mips_cpu_mem_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  int          nChecks = 0;
  int          nPass = 0;
  mips_cpu_mem_unit_if bus ();
  mips_cpu_mem_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask
  task automatic request(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic storeCase(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] wantAddr, input logic [3:0] wantBe, input logic [31:0] wantData);
    request(1'b1, sz, 1'b0, a, d);
    @(negedge clk);
    check({tag, "_wr_rd"}, {30'b0, bus.write, bus.read}, 32'd2);
    check({tag, "_addr"}, bus.address, wantAddr);
    check({tag, "_be"}, {28'b0, bus.byteenable}, {28'b0, wantBe});
    check({tag, "_wdata"}, bus.writedata, wantData);
    @(negedge clk);
    check({tag, "_resp"}, {30'b0, resp_valid, resp_error}, 32'd2);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
  endtask
  task automatic loadCase(input string tag, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] rd,
                          input logic [31:0] wantAddr, input logic [3:0] wantBe, input logic [31:0] wantData);
    bus.readdata = rd;
    request(1'b0, sz, sg, a, 32'hA5A5A5A5);
    @(negedge clk);
    check({tag, "_wr_rd"}, {30'b0, bus.write, bus.read}, 32'd1);
    check({tag, "_addr"}, bus.address, wantAddr);
    check({tag, "_be"}, {28'b0, bus.byteenable}, {28'b0, wantBe});
    @(negedge clk);
    check({tag, "_early"}, {30'b0, resp_valid, bus.read}, 32'd0);
    @(negedge clk);
    check({tag, "_resp"}, {30'b0, resp_valid, resp_error}, 32'd2);
    check({tag, "_rdata"}, resp_rdata, wantData);
    @(negedge clk);
    check({tag, "_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
  endtask
  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata = '0;
    repeat (2) @(negedge clk);
    check("rst_strobes", {28'b0, bus.read, bus.write, resp_valid, resp_error}, 32'd0);
    check("rst_addr", bus.address, 32'd0);
    check("rst_wdata", bus.writedata, 32'd0);
    check("rst_be", {28'b0, bus.byteenable}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    storeCase("st_word", 2'b10, 32'h00001004, 32'hDEADBEEF, 32'h00001004, 4'b1111, 32'hDEADBEEF);
    storeCase("st_half_hi", 2'b01, 32'h00000102, 32'h0000ABCD, 32'h00000100, 4'b1100, 32'hABCD0000);
    storeCase("st_half_lo", 2'b01, 32'h00000100, 32'h1234ABCD, 32'h00000100, 4'b0011, 32'h0000ABCD);
    storeCase("st_byte1", 2'b00, 32'h00000101, 32'hFFFFFF5A, 32'h00000100, 4'b0010, 32'h00005A00);
    loadCase("ld_sb3", 2'b00, 1'b1, 32'h00001003, 32'h80FF1234, 32'h00001000, 4'b1000, 32'hFFFFFF80);
    loadCase("ld_ub3", 2'b00, 1'b0, 32'h00001003, 32'h80FF1234, 32'h00001000, 4'b1000, 32'h00000080);
    loadCase("ld_sb0", 2'b00, 1'b1, 32'h00001000, 32'h80FF1234, 32'h00001000, 4'b0001, 32'h00000034);
    loadCase("ld_sb2", 2'b00, 1'b1, 32'h00001002, 32'h80FF1234, 32'h00001000, 4'b0100, 32'hFFFFFFFF);
    loadCase("ld_uh_hi", 2'b01, 1'b0, 32'h00000102, 32'hABCD0000, 32'h00000100, 4'b1100, 32'h0000ABCD);
    loadCase("ld_sh_hi", 2'b01, 1'b1, 32'h00000102, 32'hABCD0000, 32'h00000100, 4'b1100, 32'hFFFFABCD);
    loadCase("ld_sh_lo", 2'b01, 1'b1, 32'h00001000, 32'h80FF1234, 32'h00001000, 4'b0011, 32'h00001234);
    loadCase("ld_word", 2'b10, 1'b1, 32'h00002000, 32'h80FF1234, 32'h00002000, 4'b1111, 32'h80FF1234);
    loadCase("ld_rsvd", 2'b11, 1'b1, 32'h00002000, 32'h89ABCDEF, 32'h00002000, 4'b1111, 32'h89ABCDEF);
`ifdef MEM_MISALIGN_TRAP_EN
    bus.readdata = 32'h11223344;
    request(1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0);
    @(negedge clk);
    check("mis_word_nostrobe", {30'b0, bus.read, bus.write}, 32'd0);
    check("mis_word_noresp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("mis_word_resp", {30'b0, resp_valid, resp_error}, 32'd3);
    check("mis_word_rdata", resp_rdata, 32'd0);
    check("mis_word_nostrobe2", {30'b0, bus.read, bus.write}, 32'd0);
    @(negedge clk);
    check("mis_word_idle", {30'b0, resp_valid, req_ready}, 32'd1);
    request(1'b1, 2'b01, 1'b0, 32'h00000101, 32'h0000BEEF);
    @(negedge clk);
    check("mis_half_nostrobe", {30'b0, bus.read, bus.write}, 32'd0);
    @(negedge clk);
    check("mis_half_resp", {30'b0, resp_valid, resp_error}, 32'd3);
    @(negedge clk);
`else
    loadCase("mis_word", 2'b10, 1'b0, 32'h00000006, 32'h11223344, 32'h00000004, 4'b1111, 32'h11223344);
    storeCase("mis_half", 2'b01, 32'h00000101, 32'h0000BEEF, 32'h00000100, 4'b0011, 32'h0000BEEF);
`endif
    bus.readdata = 32'h55667788;
    bus.waitrequest = 1'b1;
    request(1'b0, 2'b10, 1'b0, 32'h00003008, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wait_read_%0d", i), {31'b0, bus.read}, 32'd1);
      check($sformatf("wait_addr_%0d", i), bus.address, 32'h00003008);
      check($sformatf("wait_be_%0d", i), {28'b0, bus.byteenable}, 32'hF);
      check($sformatf("wait_noresp_%0d", i), {31'b0, resp_valid}, 32'd0);
      if (i == 2) begin
        @(posedge clk);
        #1 bus.waitrequest = 1'b0;
      end
    end
    @(negedge clk);
    check("wait_rdata_phase", {30'b0, resp_valid, bus.read}, 32'd0);
    @(negedge clk);
    check("wait_resp", {30'b0, resp_valid, resp_error}, 32'd2);
    check("wait_rdata", resp_rdata, 32'h55667788);
    @(negedge clk);
    bus.waitrequest = 1'b1;
    request(1'b0, 2'b10, 1'b0, 32'h00004000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("tmo_read_%0d", i), {30'b0, bus.read, resp_valid}, 32'd2);
    end
    @(negedge clk);
    check("tmo_drop", {30'b0, bus.read, bus.write}, 32'd0);
    check("tmo_resp", {30'b0, resp_valid, resp_error}, 32'd3);
    check("tmo_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    check("tmo_idle", {30'b0, resp_valid, req_ready}, 32'd1);
    request(1'b1, 2'b10, 1'b0, 32'h00005000, 32'hCAFEF00D);
    @(negedge clk);
    check("rstmid_write", {30'b0, bus.write, bus.read}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("rstmid_drop", {30'b0, bus.write, bus.read}, 32'd0);
    check("rstmid_be", {28'b0, bus.byteenable}, 32'd0);
    bus.waitrequest = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_idle_%0d", i), {29'b0, resp_valid, req_ready, bus.write}, 32'd2);
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
